// File: rtl/cnn_pkg.sv
// Shared CNN datapath widths and helpers.
// An 8-bit unsigned pixel times an 8-bit signed weight fits in a 17-bit signed product.
package cnn_pkg;

    localparam int PIX_W  = 8;
    localparam int WGT_W  = 8;
    localparam int PROD_W = 17;

    // Sum width that can hold n full-scale products without overflow.
    function automatic int sum_w(input int n);
        return PROD_W + $clog2(n);
    endfunction

    // Multiply a pixel (zero-extended to 9 bits, so it stays non-negative)
    // by a signed weight.
    function automatic logic [PROD_W-1:0] pix_mul(input logic [PIX_W-1:0] pix,
                                                  input logic [WGT_W-1:0] wgt);
        logic signed [PIX_W:0]    p;
        logic signed [WGT_W-1:0]  w;
        logic signed [PROD_W-1:0] r;
        p = {1'b0, pix};
        w = wgt;
        r = p * w;
        return r;
    endfunction

endpackage

// File: rtl/mac_adder_tree.sv
// Combinational signed reduction of N products into a full-precision sum.
// Each product is sign-extended to SUM_W before accumulating, so the sum cannot wrap.
module mac_adder_tree
    import cnn_pkg::*;
#(
    parameter int N     = 9,
    parameter int SUM_W = 21
) (
    input  logic [N-1:0][PROD_W-1:0] prods,
    output logic [SUM_W-1:0]         sum
);

    logic [N-1:0][SUM_W-1:0] prods_ext;
    logic [SUM_W-1:0]        acc;

    // Sign-extend every product to the sum width, then add them together.
    always_comb begin
        acc = '0;
        for (int k = 0; k < N; k++) begin
            prods_ext[k] = {{(SUM_W-PROD_W){prods[k][PROD_W-1]}}, prods[k]};
            acc          = acc + prods_ext[k];
        end
    end

    assign sum = acc;

endmodule

// File: rtl/window_mac.sv
// window_mac: multiplies a sliding pixel window by a shifted-in weight set.
// Latency is 2 clocks: stage 1 registers the products, stage 2 registers the sum.
// Optional build macro WINDOW_MAC_RELU_EN clamps negative sums to 0 at stage 2.
module window_mac
    import cnn_pkg::*;
#(
    parameter int P_SR_DEPTH  = 3,
    parameter int NUM_SR_ROWS = 3
) (
    input  logic                                                clock,
    input  logic                                                reset,
    input  logic                                                shift_valid,
    input  logic [PIX_W*P_SR_DEPTH*NUM_SR_ROWS-1:0]             p_window_in,
    input  logic                                                weight_load,
    input  logic [WGT_W-1:0]                                    weight_in,
    output logic                                                weights_ready,
    output logic                                                mac_valid,
    output logic [sum_w(P_SR_DEPTH*NUM_SR_ROWS)-1:0]            mac_out
);

    localparam int N      = P_SR_DEPTH * NUM_SR_ROWS;
    localparam int SUM_W  = sum_w(N);
    localparam int CNT_W  = $clog2(N + 1);
    localparam int STAGES = 2;

    logic [N-1:0][WGT_W-1:0]  wgt_d, wgt_q;
    logic [CNT_W-1:0]         wcnt_d, wcnt_q;
    logic [CNT_W-1:0]         fill_d, fill_q;
    logic [N-1:0][PROD_W-1:0] prod_d, prod_q;
    logic [SUM_W-1:0]         mac_d, mac_q;
    logic [STAGES-1:0]        vld_pipe_d, vld_pipe_q;
    logic [SUM_W-1:0]         tree_sum;
    logic                     win_full;
    logic                     strobe;

    assign weights_ready = (wcnt_q == CNT_W'(N));
    // The window counts as full when this cycle's shift brings fill up to N.
    assign win_full      = (fill_q >= CNT_W'(N - 1));
    // A coincident weight load changes the weight set mid-window, so that window is dropped.
    assign strobe        = shift_valid & win_full & weights_ready & ~weight_load;

    // Weight shift chain and the two saturating counters.
    always_comb begin
        wgt_d  = wgt_q;
        wcnt_d = wcnt_q;
        fill_d = fill_q;
        if (weight_load) begin
            wgt_d[0] = weight_in;
            for (int k = 1; k < N; k++) begin
                wgt_d[k] = wgt_q[k-1];
            end
            if (wcnt_q != CNT_W'(N)) begin
                wcnt_d = wcnt_q + 1'b1;
            end
        end
        if (shift_valid && (fill_q != CNT_W'(N))) begin
            fill_d = fill_q + 1'b1;
        end
    end

    // Stage 1: capture per-tap products only for windows that will produce a result.
    always_comb begin
        prod_d = prod_q;
        if (strobe) begin
            for (int k = 0; k < N; k++) begin
                prod_d[k] = pix_mul(p_window_in[k*PIX_W +: PIX_W], wgt_q[k]);
            end
        end
    end

    mac_adder_tree #(
        .N     (N),
        .SUM_W (SUM_W)
    ) u_tree (
        .prods (prod_q),
        .sum   (tree_sum)
    );

    // Stage 2: register the sum when stage 1 holds a live window, otherwise hold.
    always_comb begin
        vld_pipe_d = {vld_pipe_q[STAGES-2:0], strobe};
        mac_d      = mac_q;
        if (vld_pipe_q[0]) begin
`ifdef WINDOW_MAC_RELU_EN
            mac_d = tree_sum[SUM_W-1] ? '0 : tree_sum;
`else
            mac_d = tree_sum;
`endif
        end
    end

    // All state clears asynchronously, which also discards in-flight results.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wgt_q      <= '0;
            wcnt_q     <= '0;
            fill_q     <= '0;
            prod_q     <= '0;
            mac_q      <= '0;
            vld_pipe_q <= '0;
        end else begin
            wgt_q      <= wgt_d;
            wcnt_q     <= wcnt_d;
            fill_q     <= fill_d;
            prod_q     <= prod_d;
            mac_q      <= mac_d;
            vld_pipe_q <= vld_pipe_d;
        end
    end

    assign mac_out   = mac_q;
    assign mac_valid = vld_pipe_q[STAGES-1];

endmodule

// File: tb/tb_window_mac.sv
// Self-checking bench for window_mac (3x3). Reference model keeps the full
// pixel and weight histories since reset and computes each result directly.
module tb_window_mac;

    localparam int N     = 9;
    localparam int SUM_W = 21;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             shift_valid = 1'b0;
    logic [8*N-1:0]   p_window_in = '0;
    logic             weight_load = 1'b0;
    logic [7:0]       weight_in = '0;
    logic             weights_ready;
    logic             mac_valid;
    logic [SUM_W-1:0] mac_out;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int     pq[$];      // pixels shifted since reset, oldest first
    int     wq[$];      // weights loaded since reset, oldest first
    int     due_q[$];   // cycle at which each expected result appears
    longint val_q[$];
    longint last_out = 0;

    window_mac #(.P_SR_DEPTH(3), .NUM_SR_ROWS(3)) dut (
        .clock         (clock),
        .reset         (reset),
        .shift_valid   (shift_valid),
        .p_window_in   (p_window_in),
        .weight_load   (weight_load),
        .weight_in     (weight_in),
        .weights_ready (weights_ready),
        .mac_valid     (mac_valid),
        .mac_out       (mac_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [SUM_W-1:0] bits(input longint v);
        return v[SUM_W-1:0];
    endfunction

    function automatic int pix_at(input int k);
        return (k < pq.size()) ? pq[pq.size()-1-k] : 0;
    endfunction

    function automatic int wgt_at(input int k);
        return (k < wq.size()) ? wq[wq.size()-1-k] : 0;
    endfunction

    // One clock: drive inputs, update the model, then check all outputs.
    task automatic step(input bit sv, input int pix, input bit wl, input int wv);
        logic signed [7:0] wb;
        longint            s;
        bit                take;
        if (sv) pq.push_back(pix & 255);
        for (int k = 0; k < N; k++) p_window_in[8*k +: 8] = 8'(pix_at(k));
        take = sv && (pq.size() >= N) && (wq.size() >= N) && !wl;
        if (take) begin
            s = 0;
            for (int k = 0; k < N; k++) s += longint'(pix_at(k)) * longint'(wgt_at(k));
`ifdef WINDOW_MAC_RELU_EN
            if (s < 0) s = 0;
`endif
            due_q.push_back(cyc + 2);
            val_q.push_back(s);
        end
        shift_valid = sv;
        weight_load = wl;
        wb          = 8'(wv);
        weight_in   = wb;
        if (wl) wq.push_back(int'(wb));
        @(posedge clock);
        #1;
        cyc++;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            void'(due_q.pop_front());
            last_out = val_q.pop_front();
            chk("mac_valid", {63'd0, mac_valid}, 64'd1);
        end else begin
            chk("mac_valid", {63'd0, mac_valid}, 64'd0);
        end
        chk("mac_out", {43'd0, mac_out}, {43'd0, bits(last_out)});
        chk("weights_ready", {63'd0, weights_ready}, {63'd0, wq.size() >= N});
    endtask

    task automatic do_reset();
        shift_valid = 1'b0;
        weight_load = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("rst_mac_out", {43'd0, mac_out}, 64'd0);
        chk("rst_mac_valid", {63'd0, mac_valid}, 64'd0);
        chk("rst_weights_ready", {63'd0, weights_ready}, 64'd0);
        pq.delete(); wq.delete(); due_q.delete(); val_q.delete();
        last_out = 0;
        p_window_in = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        // power-on reset
        #1 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("por_mac_out", {43'd0, mac_out}, 64'd0);
        chk("por_mac_valid", {63'd0, mac_valid}, 64'd0);
        chk("por_weights_ready", {63'd0, weights_ready}, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // weights all +1, pixels 0,1,2,...
        for (int i = 0; i < N; i++) step(0, 0, 1, 1);
        chk("ready_after_9", {63'd0, weights_ready}, 64'd1);
        for (int i = 0; i < N; i++) step(1, i, 0, 0);
        step(1, 9, 0, 0);
        chk("first_36", {43'd0, mac_out}, 64'd36);
        step(1, 10, 0, 0);
        chk("next_45", {43'd0, mac_out}, 64'd45);
        step(1, 11, 0, 0);
        chk("win2_10_54", {43'd0, mac_out}, 64'd54);
        step(1, 12, 0, 0);
        chk("plus9_63", {43'd0, mac_out}, 64'd63);
        chk("consecutive_valid", {63'd0, mac_valid}, 64'd1);
        for (int i = 13; i < 16; i++) step(1, i, 0, 0);
        repeat (3) step(0, 0, 0, 0);

        // weights all -1, pixels 0..8
        for (int i = 0; i < N; i++) step(0, 0, 1, -1);
        for (int i = 0; i < N; i++) step(1, i, 0, 0);
        step(0, 0, 0, 0);
`ifdef WINDOW_MAC_RELU_EN
        chk("neg_sum_relu", {43'd0, mac_out}, 64'd0);
`else
        chk("neg_sum_m36", {43'd0, mac_out}, {43'd0, bits(-36)});
`endif

        // weights 1..9 in order, pixels 255
        for (int i = 1; i <= N; i++) step(0, 0, 1, i);
        for (int i = 0; i < N; i++) step(1, 255, 0, 0);
        step(0, 0, 0, 0);
        chk("ramp_11475", {43'd0, mac_out}, 64'd11475);

        // full-scale: weights 127, pixels 255
        for (int i = 0; i < N; i++) step(0, 0, 1, 127);
        for (int i = 0; i < N; i++) step(1, 255, 0, 0);
        step(0, 0, 0, 0);
        chk("max_291465", {43'd0, mac_out}, 64'd291465);

        // coincident weight load drops exactly one window
        step(1, 255, 0, 0);
        step(1, 255, 0, 0);
        step(1, 255, 1, 127);
        chk("before_drop_valid", {63'd0, mac_valid}, 64'd1);
        step(1, 255, 0, 0);
        chk("dropped_window", {63'd0, mac_valid}, 64'd0);
        step(1, 255, 0, 0);
        chk("after_drop_valid", {63'd0, mac_valid}, 64'd1);

        // mid-stream reset with results in flight
        step(1, 7, 0, 0);
        do_reset();
        for (int i = 0; i < N; i++) step(1, i + 20, 0, 0);
        for (int i = 0; i < N - 1; i++) step(0, 0, 1, 2);
        chk("not_ready_8", {63'd0, weights_ready}, 64'd0);
        step(1, 30, 1, 2);
        step(1, 31, 0, 0);
        step(0, 0, 0, 0);
        chk("post_rst_result", {43'd0, mac_out}, {43'd0, bits(2 * (31 + 30 + 28 + 27 + 26 + 25 + 24 + 23 + 22))});

        // randomized traffic against the model, with an occasional reset
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            step($urandom_range(0, 9) < 7, int'($urandom_range(0, 255)),
                 $urandom_range(0, 9) == 0, int'($urandom_range(0, 255)));
        end
        repeat (3) step(0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/window_mac.md
WINDOW_MAC -- requirements
Module: window_mac

Interface
REQ-001 SHALL have parameter P_SR_DEPTH, default 3: window columns, matching dense_sr.
REQ-002 SHALL have parameter NUM_SR_ROWS, default 3: window rows, matching dense_sr.
REQ-003 SHALL have port clock, input, 1: single clock, rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port shift_valid, input, 1: dense_sr shifted a new pixel this cycle.
REQ-006 SHALL have port p_window_in, input, 8*P_SR_DEPTH*NUM_SR_ROWS: dense_sr p_window_out, unsigned pixels; tap k is bits [8k+7:8k], with tap 0 the newest pixel.
REQ-007 SHALL have port weight_load, input, 1: shift weight_in into the weight chain this cycle.
REQ-008 SHALL have port weight_in, input, 8: signed two's-complement weight.
REQ-009 SHALL have port weights_ready, output, 1: a full set of weights is loaded.
REQ-010 SHALL have port mac_valid, output, 1: mac_out holds a new result.
REQ-011 SHALL have port mac_out, output, SUM_W: signed sum; SUM_W = 17 + clog2(P_SR_DEPTH*NUM_SR_ROWS), which is 21 for 3x3.

Function
REQ-012 SHALL hold N = P_SR_DEPTH*NUM_SR_ROWS weight registers as a shift chain; on each weight_load, weight_in enters tap 0 and tap k moves to tap k+1.
REQ-013 SHALL therefore pair the first of N loaded weights with tap N-1 (the oldest pixel).
REQ-014 SHALL count weight_load cycles in a counter saturating at N; weights_ready = (count == N).
REQ-015 SHALL count shift_valid cycles in a fill counter saturating at N; a window is full when fill == N, counting the current shift.
REQ-016 SHALL form the window strobe, in the cycle p_window_in is sampled, as: shift_valid & window full & weights_ready & !weight_load.
REQ-017 SHALL, at stage 1, register N products: zero-extend pixel to 9 bits, multiply by the signed weight, keep 17-bit signed.
REQ-018 SHALL, at stage 2, register the full-precision signed sum of the N products into mac_out.
REQ-019 SHALL never overflow the sum; no truncation or saturation is applied.
REQ-020 SHALL pipeline the strobe alongside the data, so mac_valid asserts exactly 2 clocks after its window was sampled.
REQ-021 SHALL accept one result per clock at full throughput, with no stall input.
REQ-022 SHALL hold mac_out at its last value while mac_valid is low.
REQ-023 SHALL, when shift_valid and weight_load are both high, advance the fill counter and shift the weight chain, but drop that window (no mac_valid).
REQ-024 SHALL, when weight_load is high after weights_ready, keep shifting the chain with the count held at N; results are the user's responsibility.

Reset
REQ-025 SHALL, on reset low, asynchronously clear all weights, both counters, pipeline registers, mac_out, mac_valid and weights_ready to 0.
REQ-026 SHALL discard in-flight results on a mid-operation reset; after release, refill (N shifts) and reload (N weights) are required before mac_valid.

Configuration
REQ-027 SHALL, with macro WINDOW_MAC_RELU_EN defined, register max(sum, 0) as mac_out at stage 2.
REQ-028 SHALL, without the macro, output the signed sum unchanged; latency is 2 cycles in both builds.

Structure
REQ-029 SHALL place the pixel width (8), weight width (8), product width (17) and a SUM_W function of N in shared package cnn_pkg.
REQ-030 SHALL use one sub-module, mac_adder_tree: a combinational signed reduction of N products, instantiated before the stage-2 register.

Verification
REQ-031 SHALL cover: load 9 weights of +1; shift pixels 0,1,2,... one per clock -> first mac_valid 2 clocks after the 9th shift, mac_out = 36.
REQ-032 SHALL cover: continued shifting -> consecutive mac_valid; the window {2..10} gives mac_out = 54, then +9 per clock.
REQ-033 SHALL cover: load 9 weights of -1, pixels 0..8 -> mac_out = -36 without WINDOW_MAC_RELU_EN and 0 with it.
REQ-034 SHALL cover: load weights 1..9 in order (tap 8 = 1), all pixels 255 -> mac_out = 11475; weights all 127, pixels 255 -> mac_out = 291465 with no overflow.
REQ-035 SHALL cover: weight_load pulsed coincident with a shift after weights_ready -> mac_valid absent exactly 2 clocks later, and present on the neighbouring results.
REQ-036 SHALL cover: reset low mid-stream -> outputs 0 immediately; no mac_valid until 9 new shifts and 9 new weight loads.
